// File: rtl/geom_point_predictor.sv
// Prediction stage ahead of the saturating point adder: pairs each residual with a
// zero/previous/linear prediction and learns the reconstructed point back on consume.
module geom_point_predictor #(
    parameter int unsigned W     = 32,
    parameter int unsigned IDX_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       cfg_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic [W-1:0]     in_res_x,
    input  logic [W-1:0]     in_res_y,
    input  logic [W-1:0]     in_res_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_pred_x,
    output logic [W-1:0]     out_pred_y,
    output logic [W-1:0]     out_pred_z,
    output logic [W-1:0]     out_res_x,
    output logic [W-1:0]     out_res_y,
    output logic [W-1:0]     out_res_z,
    output logic             out_first,
    output logic [IDX_W-1:0] out_idx,
    input  logic [W-1:0]     recon_x,
    input  logic [W-1:0]     recon_y,
    input  logic [W-1:0]     recon_z
);

    localparam int unsigned EW = W + 2;
    localparam logic [1:0] MODE_ZERO = 2'd0;
    localparam logic [1:0] MODE_LIN  = 2'd2;

    logic [2:0][W-1:0] res_in;
    logic [2:0][W-1:0] recon_in;
    logic [2:0][W-1:0] pred_c;

    logic              valid_q, valid_d;
    logic              first_q, first_d;
    logic [1:0]        mode_q, mode_d;
    logic [1:0]        hist_cnt_q, hist_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [2:0][W-1:0] res_q, res_d;
    logic [2:0][W-1:0] h1_q, h1_d;
    logic [2:0][W-1:0] h0_q, h0_d;

    logic accept;
    logic consume;

    assign res_in   = {in_res_z, in_res_y, in_res_x};
    assign recon_in = {recon_z, recon_y, recon_x};

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = valid_q && out_ready;

    // 2*a - b evaluated with two guard bits, clamped to the signed W-bit range.
    function automatic logic [W-1:0] lin_sat(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [EW-1:0] t;
        logic [W-1:0]         r;
        t = (EW'(signed'(a)) <<< 1) - EW'(signed'(b));
        if ((&t[EW-1:W-1]) || !(|t[EW-1:W-1])) begin
            r = t[W-1:0];
        end else if (t[EW-1]) begin
            r = {1'b1, {(W-1){1'b0}}};
        end else begin
            r = {1'b0, {(W-1){1'b1}}};
        end
        return r;
    endfunction

    // Prediction depends only on registered state; a fresh frame sees empty history.
    always_comb begin
        pred_c = '0;
        if (valid_q && !first_q && (hist_cnt_q != 2'd0)) begin
            case (mode_q)
                MODE_ZERO: pred_c = '0;
                MODE_LIN: begin
                    if (hist_cnt_q == 2'd2) begin
                        for (int a = 0; a < 3; a++) begin
                            pred_c[a] = lin_sat(h1_q[a], h0_q[a]);
                        end
                    end else begin
                        pred_c = h1_q;
                    end
                end
                default: pred_c = h1_q;
            endcase
        end
    end

    always_comb begin
        valid_d    = valid_q;
        first_d    = first_q;
        mode_d     = mode_q;
        hist_cnt_d = hist_cnt_q;
        idx_d      = idx_q;
        res_d      = res_q;
        h1_d       = h1_q;
        h0_d       = h0_q;

        // History learns from the entry leaving, before any new entry replaces it.
        if (consume) begin
            valid_d = 1'b0;
            idx_d   = idx_q + IDX_W'(1);
            h1_d    = recon_in;
            if (first_q) begin
                h0_d       = '0;
                hist_cnt_d = 2'd1;
            end else begin
                h0_d       = h1_q;
                hist_cnt_d = (hist_cnt_q == 2'd2) ? 2'd2 : hist_cnt_q + 2'd1;
            end
        end

        if (accept) begin
            valid_d = 1'b1;
            first_d = in_first;
            mode_d  = cfg_mode;
            res_d   = res_in;
            if (in_first) begin
                idx_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            mode_q     <= 2'd0;
            hist_cnt_q <= 2'd0;
            idx_q      <= '0;
            res_q      <= '0;
            h1_q       <= '0;
            h0_q       <= '0;
        end else begin
            valid_q    <= valid_d;
            first_q    <= first_d;
            mode_q     <= mode_d;
            hist_cnt_q <= hist_cnt_d;
            idx_q      <= idx_d;
            res_q      <= res_d;
            h1_q       <= h1_d;
            h0_q       <= h0_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_first  = first_q;
    assign out_idx    = idx_q;
    assign out_res_x  = res_q[0];
    assign out_res_y  = res_q[1];
    assign out_res_z  = res_q[2];
    assign out_pred_x = pred_c[0];
    assign out_pred_y = pred_c[1];
    assign out_pred_z = pred_c[2];

endmodule

// File: tb/tb_geom_point_predictor.sv
// Directed vector bench for geom_point_predictor: cycle table plus streaming and reset sequences.
module tb_geom_point_predictor;

    localparam int unsigned W     = 32;
    localparam int unsigned IDX_W = 16;

    logic             clk;
    logic             rst_n;
    logic [1:0]       cfg_mode;
    logic             in_valid;
    logic             in_ready;
    logic             in_first;
    logic [W-1:0]     in_res_x, in_res_y, in_res_z;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_pred_x, out_pred_y, out_pred_z;
    logic [W-1:0]     out_res_x, out_res_y, out_res_z;
    logic             out_first;
    logic [IDX_W-1:0] out_idx;
    logic [W-1:0]     recon_x, recon_y, recon_z;

    geom_point_predictor #(.W(W), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_mode   (cfg_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_first   (in_first),
        .in_res_x   (in_res_x),
        .in_res_y   (in_res_y),
        .in_res_z   (in_res_z),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pred_x (out_pred_x),
        .out_pred_y (out_pred_y),
        .out_pred_z (out_pred_z),
        .out_res_x  (out_res_x),
        .out_res_y  (out_res_y),
        .out_res_z  (out_res_z),
        .out_first  (out_first),
        .out_idx    (out_idx),
        .recon_x    (recon_x),
        .recon_y    (recon_y),
        .recon_z    (recon_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        fst;
        logic [1:0]  md;
        logic [31:0] rx, ry, rz;
        logic        ordy;
        logic [31:0] cx, cy, cz;
        logic        eov;
        logic        erdy;
        logic [31:0] px, py, pz;
        logic [15:0] eidx;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic fst, input logic [1:0] md,
                         input logic [31:0] rx, input logic [31:0] ry, input logic [31:0] rz,
                         input logic ordy,
                         input logic [31:0] cx, input logic [31:0] cy, input logic [31:0] cz);
        in_valid  = iv;
        in_first  = fst;
        cfg_mode  = md;
        in_res_x  = rx;
        in_res_y  = ry;
        in_res_z  = rz;
        out_ready = ordy;
        recon_x   = cx;
        recon_y   = cy;
        recon_z   = cz;
    endtask

    function automatic vec_t mk(input logic iv, input logic fst, input logic [1:0] md,
                                input int rx, input int ry, input int rz, input logic ordy,
                                input int cx, input int cy, input int cz,
                                input logic eov, input logic erdy,
                                input int px, input int py, input int pz, input int eidx);
        vec_t v;
        v.iv = iv; v.fst = fst; v.md = md;
        v.rx = rx; v.ry = ry; v.rz = rz; v.ordy = ordy;
        v.cx = cx; v.cy = cy; v.cz = cz;
        v.eov = eov; v.erdy = erdy;
        v.px = px; v.py = py; v.pz = pz; v.eidx = 16'(eidx);
        return v;
    endfunction

    vec_t        vecs[$];
    logic [31:0] exp_rx, exp_ry, exp_rz;
    int          cons;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 0, 0, 0, 1'b0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_idx",   32'(out_idx), 32'd0);
        chk("rst pred_x",    out_pred_x, 32'd0);
        chk("rst res_x",     out_res_x, 32'd0);
        chk("rst out_first", 32'(out_first), 32'd0);
        chk("rst in_ready",  32'(in_ready), 32'd1);

        //                iv fst md  res            ordy recon                  ov rdy pred                   idx
        vecs.push_back(mk(1, 1, 1, 10, 20, 30,     1, 0, 0, 0,                  0, 1, 0, 0, 0,               0));
        vecs.push_back(mk(1, 0, 1, 1, 1, 1,        1, 10, 20, 30,               1, 1, 0, 0, 0,               0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,        1, 11, 21, 31,               1, 1, 10, 20, 30,            1));
        vecs.push_back(mk(1, 1, 2, 100, 0, -5,     1, 0, 0, 0,                  0, 1, 0, 0, 0,               2));
        vecs.push_back(mk(1, 0, 2, 10, 4, -4,      1, 100, 0, -5,               1, 1, 0, 0, 0,               0));
        vecs.push_back(mk(1, 0, 2, 10, 4, -4,      1, 110, 4, -9,               1, 1, 100, 0, -5,            1));
        vecs.push_back(mk(0, 0, 2, 0, 0, 0,        1, 120, 8, -13,              1, 1, 120, 8, -13,           2));
        vecs.push_back(mk(1, 1, 2, 0, 0, 0,        1, 0, 0, 0,                  0, 1, 0, 0, 0,               3));
        vecs.push_back(mk(1, 0, 2, 0, 0, 0,        1, 0, 0, 0,                  1, 1, 0, 0, 0,               0));
        vecs.push_back(mk(1, 0, 2, 0, 0, 0,        1, 32'h7FFFFFF0, 32'h80000000, 5, 1, 1, 0, 0, 0,      1));
        vecs.push_back(mk(0, 0, 2, 0, 0, 0,        1, 0, 0, 0,      1, 1, 32'h7FFFFFFF, 32'h80000000, 10, 2));
        vecs.push_back(mk(1, 1, 1, 1, 1, 1,        1, 0, 0, 0,                  0, 1, 0, 0, 0,               3));
        vecs.push_back(mk(1, 0, 1, 1, 1, 1,        1, 5, 5, 5,                  1, 1, 0, 0, 0,               0));
        vecs.push_back(mk(1, 0, 1, 1, 1, 1,        1, 6, 6, 6,                  1, 1, 5, 5, 5,               1));
        vecs.push_back(mk(1, 0, 1, 1, 1, 1,        1, 7, 7, 7,                  1, 1, 6, 6, 6,               2));
        vecs.push_back(mk(1, 0, 1, 1, 1, 1,        1, 8, 8, 8,                  1, 1, 7, 7, 7,               3));
        vecs.push_back(mk(1, 1, 2, 2, 2, 2,        1, 9, 9, 9,                  1, 1, 8, 8, 8,               4));
        vecs.push_back(mk(1, 0, 2, 3, 3, 3,        1, 50, 60, 70,               1, 1, 0, 0, 0,               0));
        vecs.push_back(mk(0, 0, 2, 0, 0, 0,        1, 0, 0, 0,                  1, 1, 50, 60, 70,            1));
        vecs.push_back(mk(1, 1, 1, 7, 8, 9,        0, 0, 0, 0,                  0, 1, 0, 0, 0,               2));
        vecs.push_back(mk(1, 0, 1, 99, 99, 99,     0, 0, 0, 0,                  1, 0, 0, 0, 0,               0));
        vecs.push_back(mk(1, 0, 1, 99, 99, 99,     0, 0, 0, 0,                  1, 0, 0, 0, 0,               0));
        vecs.push_back(mk(1, 0, 1, 99, 99, 99,     0, 0, 0, 0,                  1, 0, 0, 0, 0,               0));
        vecs.push_back(mk(1, 0, 1, 1, 2, 3,        1, 40, 41, 42,               1, 1, 0, 0, 0,               0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,        0, 0, 0, 0,                  1, 0, 40, 41, 42,            1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,        1, 0, 0, 0,                  1, 1, 40, 41, 42,            1));
        vecs.push_back(mk(1, 1, 0, 4, 4, 4,        1, 0, 0, 0,                  0, 1, 0, 0, 0,               2));
        vecs.push_back(mk(1, 0, 0, 4, 4, 4,        1, 30, 30, 30,               1, 1, 0, 0, 0,               0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,        1, 0, 0, 0,                  1, 1, 0, 0, 0,               1));

        exp_rx = '0; exp_ry = '0; exp_rz = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].fst, vecs[i].md, vecs[i].rx, vecs[i].ry, vecs[i].rz,
                  vecs[i].ordy, vecs[i].cx, vecs[i].cy, vecs[i].cz);
            #1;
            chk($sformatf("r%0d out_valid", i), 32'(out_valid), 32'(vecs[i].eov));
            chk($sformatf("r%0d in_ready", i),  32'(in_ready), 32'(vecs[i].erdy));
            chk($sformatf("r%0d out_idx", i),   32'(out_idx), 32'(vecs[i].eidx));
            chk($sformatf("r%0d pred_x", i),    out_pred_x, vecs[i].px);
            chk($sformatf("r%0d pred_y", i),    out_pred_y, vecs[i].py);
            chk($sformatf("r%0d pred_z", i),    out_pred_z, vecs[i].pz);
            if (vecs[i].eov) begin
                chk($sformatf("r%0d res_x", i), out_res_x, exp_rx);
                chk($sformatf("r%0d res_y", i), out_res_y, exp_ry);
                chk($sformatf("r%0d res_z", i), out_res_z, exp_rz);
            end
            if (vecs[i].iv && vecs[i].erdy) begin
                exp_rx = vecs[i].rx; exp_ry = vecs[i].ry; exp_rz = vecs[i].rz;
            end
        end

        // Streaming: 8 points back-to-back in reserved mode 3 (behaves as previous-point).
        @(negedge clk);
        drive(1'b1, 1'b1, 2'd3, 0, 0, 0, 1'b1, 0, 0, 0);
        #1;
        chk("stream start out_valid", 32'(out_valid), 32'd0);
        cons = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            drive((i < 8), 1'b0, 2'd3, 32'(i), 32'(i), 32'(i), 1'b1,
                  32'(100 + i), 32'(200 + i), 32'(300 + i));
            #1;
            if (out_valid && out_ready) cons++;
            chk($sformatf("stream%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stream%0d out_idx", i), 32'(out_idx), 32'(i - 1));
            chk($sformatf("stream%0d res_x", i), out_res_x, 32'(i - 1));
            chk($sformatf("stream%0d pred_x", i), out_pred_x, (i == 1) ? 32'd0 : 32'(100 + i - 1));
            chk($sformatf("stream%0d pred_z", i), out_pred_z, (i == 1) ? 32'd0 : 32'(300 + i - 1));
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd1, 0, 0, 0, 1'b1, 0, 0, 0);
        #1;
        chk("stream consumes", 32'(cons), 32'd8);
        chk("stream drained", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-frame with a point presented and history loaded.
        @(negedge clk);
        drive(1'b1, 1'b1, 2'd1, 5, 5, 5, 1'b1, 0, 0, 0);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd1, 6, 6, 6, 1'b1, 77, 77, 77);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd1, 0, 0, 0, 1'b0, 0, 0, 0);
        #1;
        chk("pre-rst pred_x", out_pred_x, 32'd77);
        chk("pre-rst out_idx", 32'(out_idx), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst pred_x", out_pred_x, 32'd0);
        chk("async rst out_idx", 32'(out_idx), 32'd0);
        chk("async rst res_x", out_res_x, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd1, 2, 2, 2, 1'b0, 0, 0, 0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd1, 0, 0, 0, 1'b0, 0, 0, 0);
        #1;
        chk("post-rst out_valid", 32'(out_valid), 32'd1);
        chk("post-rst pred_x", out_pred_x, 32'd0);
        chk("post-rst out_idx", 32'(out_idx), 32'd0);
        chk("post-rst res_x", out_res_x, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
